// File: rtl/cortex_m0_nvic_arb_if.sv
// NVIC port bundle: register bus, interrupt lines and the exception handshake to the core.
// Handshake: exc_req/exc_num are held by the NVIC; a transfer happens on a rising edge where
// exc_req=1 and exc_ack=1, after which exc_req is low for at least one cycle. exc_ret is a
// single-cycle strobe with no back-pressure.
interface cortex_m0_nvic_arb_if #(
   parameter int N_EXT_INT = 32
);
   logic [N_EXT_INT-1:0] ext_int;
   logic                 nmi;
   logic                 primask;
   logic                 bus_sel;
   logic                 bus_wr;
   logic [9:0]           bus_addr;
   logic [31:0]          bus_wdata;
   logic [31:0]          bus_rdata;
   logic                 exc_req;
   logic [5:0]           exc_num;
   logic                 exc_ack;
   logic                 exc_ret;
   logic [5:0]           exc_ret_num;

   modport master (
      output ext_int, nmi, primask, bus_sel, bus_wr, bus_addr, bus_wdata,
             exc_ack, exc_ret, exc_ret_num,
      input  bus_rdata, exc_req, exc_num
   );

   modport slave (
      input  ext_int, nmi, primask, bus_sel, bus_wr, bus_addr, bus_wdata,
             exc_ack, exc_ret, exc_ret_num,
      output bus_rdata, exc_req, exc_num
   );
endinterface

// File: rtl/cortex_m0_nvic_arb.sv
// Nested vectored interrupt controller: enable/pending/active/priority state for up to 32 IRQs
// plus NMI, NVIC register bus, and registered arbitration of the best eligible exception.
module cortex_m0_nvic_arb #(
   parameter int N_EXT_INT = 32,
   parameter int PRIO_BITS = 2
) (
   input logic                  clk_i,
   input logic                  reset_i,
   cortex_m0_nvic_arb_if.slave  nvic
);

   localparam logic [32:0] MASK_WIDE = (33'd1 << N_EXT_INT) - 33'd1;
   localparam logic [31:0] IMPL      = MASK_WIDE[31:0];

   logic [31:0] ext_q, ext_d, hold_q, hold_d;
   logic [31:0] en_q, en_d, pend_q, pend_d, act_q, act_d;
   logic [31:0][PRIO_BITS-1:0] prio_q, prio_d;
   logic        nmi_q, nmi_hold_q, nmi_hold_d;
   logic        nmi_pend_q, nmi_pend_d, nmi_act_q, nmi_act_d;
   logic        exc_req_q, exc_req_d;
   logic [5:0]  exc_num_q, exc_num_d;
   logic [31:0] rdata_q, rdata_d;

   logic [31:0] ext32, edge32;
   logic [7:0]  word_a;
   logic        wr, rd, ipr_wr;
   logic [31:0] iser, icer, ispr, icpr;
   logic        ack_v, ack_nmi, ret_nmi, nmi_edge;
   logic [31:0] ack_vec, ret_vec, repend, elig;
   logic        run_valid, cand_found;
   logic [PRIO_BITS-1:0] run_prio, cand_prio;
   logic [4:0]  cand_idx;
   logic        irq_ok, any_cand;
   logic [5:0]  cand_num;

   assign ext32  = 32'(nvic.ext_int);
   assign word_a = 8'(nvic.bus_addr >> 2);
   assign wr     = nvic.bus_sel & nvic.bus_wr;
   assign rd     = nvic.bus_sel & ~nvic.bus_wr;
   assign ipr_wr = wr && (word_a[7:3] == 5'b11000);
   assign iser   = (wr && word_a == 8'h00) ? (nvic.bus_wdata & IMPL) : 32'd0;
   assign icer   = (wr && word_a == 8'h20) ? (nvic.bus_wdata & IMPL) : 32'd0;
   assign ispr   = (wr && word_a == 8'h40) ? (nvic.bus_wdata & IMPL) : 32'd0;
   assign icpr   = (wr && word_a == 8'h60) ? (nvic.bus_wdata & IMPL) : 32'd0;

   // hold_q masks lines that were already high when reset released until they drop once
   assign edge32     = ext32 & ~ext_q & ~hold_q;
   assign hold_d     = hold_q & ext32;
   assign nmi_edge   = nvic.nmi & ~nmi_q & ~nmi_hold_q;
   assign nmi_hold_d = nmi_hold_q & nvic.nmi;

   always_comb begin
      ack_v   = nvic.exc_ack & exc_req_q;
      ack_nmi = ack_v && (exc_num_q == 6'd2);
      ack_vec = 32'd0;
      if (ack_v && exc_num_q >= 6'd16 && exc_num_q <= 6'd47)
         ack_vec = (32'd1 << {exc_num_q[5], exc_num_q[3:0]}) & IMPL;
      ret_nmi = nvic.exc_ret && (nvic.exc_ret_num == 6'd2) && nmi_act_q;
      ret_vec = 32'd0;
      if (nvic.exc_ret && nvic.exc_ret_num >= 6'd16 && nvic.exc_ret_num <= 6'd47)
         ret_vec = (32'd1 << {nvic.exc_ret_num[5], nvic.exc_ret_num[3:0]}) & act_q;
      repend = ret_vec & ext32;
   end

   // Sets beat clears on the same bit: enable set over ICER, pend sources over ICPR/ack
   always_comb begin
      en_d       = (en_q & ~icer) | iser;
      pend_d     = (pend_q & ~(icpr | ack_vec)) | edge32 | ispr | repend;
      act_d      = (act_q | ack_vec) & ~ret_vec;
      nmi_pend_d = (nmi_pend_q & ~ack_nmi) | nmi_edge;
      nmi_act_d  = (nmi_act_q | ack_nmi) & ~ret_nmi;
      prio_d     = prio_q;
      for (int i = 0; i < 32; i++) begin
         if (ipr_wr && word_a[2:0] == 3'(i >> 2) && IMPL[i])
            prio_d[i] = nvic.bus_wdata[8*(i%4)+7 -: PRIO_BITS];
      end
   end

   always_comb begin
      run_valid = 1'b0;
      run_prio  = '0;
      for (int i = 0; i < 32; i++) begin
         if (act_q[i] && (!run_valid || prio_q[i] < run_prio)) begin
            run_valid = 1'b1;
            run_prio  = prio_q[i];
         end
      end
   end

   // Ascending scan with strict compare keeps the lowest IRQ number on priority ties
   always_comb begin
      elig       = en_q & pend_q & ~act_q & {32{~nvic.primask}};
      cand_found = 1'b0;
      cand_prio  = '0;
      cand_idx   = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (elig[i] && (!cand_found || prio_q[i] < cand_prio)) begin
            cand_found = 1'b1;
            cand_prio  = prio_q[i];
            cand_idx   = 5'(i);
         end
      end
      irq_ok   = cand_found && !nmi_act_q && (!run_valid || cand_prio < run_prio);
      any_cand = 1'b0;
      cand_num = exc_num_q;
      if (nmi_pend_q && !nmi_act_q) begin
         any_cand = 1'b1;
         cand_num = 6'd2;
      end else if (irq_ok) begin
         any_cand = 1'b1;
         cand_num = 6'd16 + {1'b0, cand_idx};
      end
      exc_req_d = ack_v ? 1'b0 : any_cand;
      exc_num_d = (!ack_v && any_cand) ? cand_num : exc_num_q;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd) begin
         rdata_d = 32'd0;
         case (word_a)
            8'h00, 8'h20: rdata_d = en_q;
            8'h40, 8'h60: rdata_d = pend_q;
            default: begin
               if (word_a[7:3] == 5'b11000) begin
                  for (int k = 0; k < 4; k++)
                     rdata_d[8*k+7 -: PRIO_BITS] = prio_q[{word_a[2:0], 2'(k)}];
               end
            end
         endcase
      end
   end

   assign ext_d = ext32;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ext_q      <= '0;
         hold_q     <= ext32;
         nmi_q      <= 1'b0;
         nmi_hold_q <= nvic.nmi;
         en_q       <= '0;
         pend_q     <= '0;
         act_q      <= '0;
         prio_q     <= '0;
         nmi_pend_q <= 1'b0;
         nmi_act_q  <= 1'b0;
         exc_req_q  <= 1'b0;
         exc_num_q  <= 6'd0;
         rdata_q    <= 32'd0;
      end else begin
         ext_q      <= ext_d;
         hold_q     <= hold_d;
         nmi_q      <= nvic.nmi;
         nmi_hold_q <= nmi_hold_d;
         en_q       <= en_d;
         pend_q     <= pend_d;
         act_q      <= act_d;
         prio_q     <= prio_d;
         nmi_pend_q <= nmi_pend_d;
         nmi_act_q  <= nmi_act_d;
         exc_req_q  <= exc_req_d;
         exc_num_q  <= exc_num_d;
         rdata_q    <= rdata_d;
      end
   end

   assign nvic.exc_req   = exc_req_q;
   assign nvic.exc_num   = exc_num_q;
   assign nvic.bus_rdata = rdata_q;

endmodule

// File: tb/tb_cortex_m0_nvic_arb.sv
// Directed bench for cortex_m0_nvic_arb with scoreboard queues for read data and exceptions.
module tb_cortex_m0_nvic_arb;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic [31:0] rd_exp_q[$];
   logic [5:0]  exc_exp_q[$];

   cortex_m0_nvic_arb_if #(.N_EXT_INT(32)) nif ();

   cortex_m0_nvic_arb #(.N_EXT_INT(32), .PRIO_BITS(2)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .nvic    (nif.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // monitor
   logic       rd_seen  = 1'b0;
   logic       prev_req = 1'b0;
   logic [5:0] prev_num = 6'd0;

   always @(posedge clk) rd_seen <= nif.bus_sel & ~nif.bus_wr;

   always @(negedge clk) begin
      logic [31:0] er;
      logic [5:0]  en;
      if (rd_seen) begin
         checks++;
         if (rd_exp_q.size() == 0) begin
            errors++;
            $display("FAIL rdata_unexpected: got 0x%08h, no read expected", nif.bus_rdata);
         end else begin
            er = rd_exp_q.pop_front();
            if (nif.bus_rdata !== er) begin
               errors++;
               $display("FAIL rdata: got 0x%08h, required 0x%08h", nif.bus_rdata, er);
            end
         end
      end
      if (nif.exc_req && (!prev_req || nif.exc_num != prev_num)) begin
         checks++;
         if (exc_exp_q.size() == 0) begin
            errors++;
            $display("FAIL exc_unexpected: exc_num=%0d presented, none required", nif.exc_num);
         end else begin
            en = exc_exp_q.pop_front();
            if (nif.exc_num !== en) begin
               errors++;
               $display("FAIL exc_num: got %0d, required %0d", nif.exc_num, en);
            end
         end
      end
      prev_req = nif.exc_req;
      prev_num = nif.exc_num;
   end

   // driver tasks
   task automatic tick(int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic bus_write(logic [9:0] addr, logic [31:0] data);
      nif.bus_sel   = 1'b1;
      nif.bus_wr    = 1'b1;
      nif.bus_addr  = addr;
      nif.bus_wdata = data;
      tick();
      nif.bus_sel   = 1'b0;
      nif.bus_wr    = 1'b0;
   endtask

   task automatic bus_read(logic [9:0] addr, logic [31:0] exp);
      rd_exp_q.push_back(exp);
      nif.bus_sel  = 1'b1;
      nif.bus_wr   = 1'b0;
      nif.bus_addr = addr;
      tick();
      nif.bus_sel  = 1'b0;
   endtask

   task automatic expect_exc(logic [5:0] num);
      exc_exp_q.push_back(num);
   endtask

   task automatic pulse(logic [31:0] m);
      nif.ext_int = nif.ext_int | m;
      tick();
      nif.ext_int = nif.ext_int & ~m;
   endtask

   task automatic do_ack(string tag);
      int n = 0;
      while (!nif.exc_req && n < 20) begin
         tick();
         n++;
      end
      checks++;
      if (!nif.exc_req) begin
         errors++;
         $display("FAIL ack_wait_%s: exc_req=0 after 20 cycles, required 1", tag);
      end else begin
         nif.exc_ack = 1'b1;
         tick();
         nif.exc_ack = 1'b0;
      end
   endtask

   task automatic do_ret(logic [5:0] num);
      nif.exc_ret     = 1'b1;
      nif.exc_ret_num = num;
      tick();
      nif.exc_ret     = 1'b0;
   endtask

   // stimulus
   initial begin
      reset           = 1'b1;
      nif.ext_int     = '1;
      nif.nmi         = 1'b0;
      nif.primask     = 1'b0;
      nif.bus_sel     = 1'b0;
      nif.bus_wr      = 1'b0;
      nif.bus_addr    = 10'd0;
      nif.bus_wdata   = 32'd0;
      nif.exc_ack     = 1'b0;
      nif.exc_ret     = 1'b0;
      nif.exc_ret_num = 6'd0;
      tick(3);
      reset = 1'b0;
      tick();

      // reset state with all lines held high
      check("reset_exc_req", 32'(nif.exc_req), 32'd0);
      check("reset_exc_num", 32'(nif.exc_num), 32'd0);
      check("reset_rdata", nif.bus_rdata, 32'd0);
      bus_read(10'h100, 32'h0);
      bus_read(10'h000, 32'h0);
      bus_read(10'h300, 32'h0);
      nif.ext_int = '0;
      tick(2);
      bus_read(10'h100, 32'h0);

      // two simultaneous edges, lower priority value wins, no preemption by equal/lower
      bus_write(10'h000, 32'h5);
      bus_write(10'h300, 32'h0000C040);
      bus_read(10'h300, 32'h0000C040);
      expect_exc(6'd18);
      pulse(32'h5);
      do_ack("irq2");
      tick(4);
      bus_read(10'h100, 32'h1);
      expect_exc(6'd16);
      do_ret(6'd18);
      do_ack("irq0");
      do_ret(6'd16);
      tick(2);

      // nesting: IRQ1 preempts IRQ3, equal-priority IRQ5 waits for return of IRQ3
      bus_write(10'h300, 32'h80004040);
      bus_write(10'h304, 32'h00008000);
      bus_write(10'h000, 32'h2A);
      bus_read(10'h304, 32'h00008000);
      expect_exc(6'd19);
      pulse(32'h8);
      do_ack("irq3");
      expect_exc(6'd17);
      pulse(32'h2);
      do_ack("irq1");
      pulse(32'h20);
      tick(3);
      do_ret(6'd17);
      tick(3);
      expect_exc(6'd21);
      do_ret(6'd19);
      do_ack("irq5");
      do_ret(6'd21);
      tick(2);

      // NMI with primask set and an IRQ active
      expect_exc(6'd16);
      pulse(32'h1);
      do_ack("irq0_b");
      nif.primask = 1'b1;
      pulse(32'h2);
      tick(2);
      expect_exc(6'd2);
      nif.nmi = 1'b1;
      tick();
      check("nmi_lat_t", 32'(nif.exc_req), 32'd0);
      nif.nmi = 1'b0;
      tick();
      check("nmi_lat_t1_req", 32'(nif.exc_req), 32'd1);
      check("nmi_lat_t1_num", 32'(nif.exc_num), 32'd2);
      do_ack("nmi");
      tick(2);
      do_ret(6'd2);
      tick(2);
      do_ret(6'd16);
      tick(2);
      expect_exc(6'd17);
      nif.primask = 1'b0;
      do_ack("irq1_b");
      do_ret(6'd17);
      tick(2);

      // ICPR clear loses to a same-cycle edge; ISPR software pend
      expect_exc(6'd16);
      nif.ext_int[0] = 1'b1;
      bus_write(10'h180, 32'h1);
      nif.ext_int[0] = 1'b0;
      bus_read(10'h100, 32'h1);
      do_ack("irq0_c");
      bus_write(10'h000, 32'h10);
      expect_exc(6'd20);
      bus_write(10'h100, 32'h10);
      do_ack("irq4");
      do_ret(6'd20);
      do_ret(6'd16);
      tick(2);
      bus_write(10'h080, 32'h20);
      bus_read(10'h000, 32'h1F);
      bus_read(10'h080, 32'h1F);

      // level-held line re-pends on return
      expect_exc(6'd18);
      nif.ext_int[2] = 1'b1;
      do_ack("irq2_lvl");
      tick(2);
      expect_exc(6'd18);
      do_ret(6'd18);
      check("repend_t", 32'(nif.exc_req), 32'd0);
      tick();
      check("repend_t1_req", 32'(nif.exc_req), 32'd1);
      check("repend_t1_num", 32'(nif.exc_num), 32'd18);
      nif.ext_int[2] = 1'b0;
      do_ack("irq2_lvl2");
      do_ret(6'd18);
      tick(2);

      // unimplemented priority bits, unmapped offset
      bus_write(10'h31C, 32'hFFFFFFFF);
      bus_read(10'h31C, 32'hC0C0C0C0);
      bus_write(10'h200, 32'hFFFFFFFF);
      bus_read(10'h200, 32'h0);

      // reset mid-operation
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
      tick();
      check("midreset_exc_req", 32'(nif.exc_req), 32'd0);
      check("midreset_exc_num", 32'(nif.exc_num), 32'd0);
      bus_read(10'h000, 32'h0);
      bus_read(10'h300, 32'h0);
      tick(4);

      checks++;
      if (exc_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
         errors++;
         $display("FAIL queues_drained: %0d exc and %0d reads outstanding, required 0",
                  exc_exp_q.size(), rd_exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cortex_m0_nvic_arb.md
# cortex_m0_nvic_arb

Parametrised nested vectored interrupt controller for the cortex-m0 cpu complex, successor to the fixed 32-register NVIC shell. It holds enable, pending, active and priority state for up to 32 external interrupts plus NMI. It exposes the architectural NVIC registers on a simple little-endian word bus and arbitrates the highest-priority eligible exception to the core over a request/acknowledge/return handshake with nesting.

## Interface
- N_EXT_INT, 32, number of external interrupt lines (1..32); unimplemented bits read 0, ignore writes
- PRIO_BITS, 2, implemented priority bits per IRQ, stored in byte bits [7:8-PRIO_BITS]
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ext_int  in  N_EXT_INT  interrupt lines, synchronous to clk
- nmi  in  1  non-maskable interrupt line
- primask  in  1  when 1, masks all external IRQs (not NMI)
- bus_sel  in  1  bus access this cycle
- bus_wr  in  1  1=write, 0=read
- bus_addr  in  10  byte offset from NVIC base 0xE000E100, word aligned ([1:0] ignored)
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, registered
- exc_req  out  1  exception request to core
- exc_num  out  6  exception number: 2=NMI, 16+n=IRQ n
- exc_ack  in  1  core accepts exc_num this cycle
- exc_ret  in  1  core returns from exception exc_ret_num
- exc_ret_num  in  6  exception being returned from

## Operation
- Register map (offset): 0x000 ISER, 0x080 ICER, 0x100 ISPR, 0x180 ICPR, 0x300–0x31C IPR0–IPR7 (byte k of IPRj = IRQ 4j+k). ISER/ICER read enable; ISPR/ICPR read pending. Set regs: write-1-to-set; clear regs: write-1-to-clear; zeros no effect. IPR: plain write, unimplemented low bits read 0. Unmapped offsets read 0, writes ignored.
- Edge detect: ext_int_q/nmi_q register previous values; rising edge (line=1, q=0) sets pending.
- Per-IRQ state: enable, pending, active. NMI: nmi_pend, nmi_act.
- Running priority: NMI active -> -2 (blocks all); else lowest numeric priority among active IRQs; none active -> idle (lower than any IRQ).
- Candidate: nmi_pend and not nmi_act -> NMI. Else IRQ with enable & pending & !active & !primask, lowest priority value, ties -> lowest IRQ number; eligible only if priority strictly numerically lower than running priority (idle accepts any).
- exc_req/exc_num registered from candidate; when exc_req=0, exc_num holds last value.
- exc_ack with exc_req=1: clears pending, sets active for exc_num; exc_req forced 0 the following cycle. exc_ack while exc_req=0 ignored.
- exc_ret: clears active of exc_ret_num; if that IRQ line is still 1, pending re-set same edge. Return for non-active number ignored.
- Same-cycle priority per bit: sets (edge, ISPR, re-pend) win over clears (ICPR, ack). ISER and ICER same bit: enable set wins.
- Priority change of an active/pending IRQ takes effect in next arbitration.

## Timing
- Reset: all enable/pending/active/priority = 0, nmi_pend/nmi_act = 0, edge regs = 0, exc_req=0, exc_num=0, bus_rdata=0.
- Edge at edge t (line first sampled 1) -> pending visible at t; exc_req=1 after edge t+1 (2-cycle latency from line rise).
- Read: bus_sel&!bus_wr at edge t -> bus_rdata valid after edge t, held until next read. Write takes effect at edge t; reads the same register in the next cycle show the new value.
- Reset mid-operation: all state cleared in the one cycle; a line held high at reset deassertion is not an edge until it drops and rises.

## Test plan
- Reset with ext_int=all-ones held -> exc_req=0, ISPR reads 0x0, all regs 0 after reset.
- ISER=0x5; IPR0=0x0000C040; pulse ext_int[0],[2] same cycle -> exc_num=18 (prio 0x00 < 0x40); ack; exc_req drops; no preemption by 16; ret 18 -> exc_num=16.
- IRQ3 active at prio 0x80; IRQ1 (prio 0x40) rises -> nested exc_num=17; equal prio 0x80 IRQ5 -> no request until ret.
- nmi rises while IRQ active and primask=1 -> exc_num=2 at t+1; IRQs suppressed until ret 2 and primask=0.
- Same cycle ICPR write 0x1 and ext_int[0] edge -> ISPR bit0 reads 1; ISPR write bit4 with enable -> exc_num=20.
- Level line held high through ret -> re-pended, exc_req reasserts next cycle with same exc_num.
